// File: rtl/dmem_store_checker_if.sv
// rtl/dmem_store_checker_if.sv - core data-memory port bundle (memwrite/dataadr/writedata/readdata)
interface dmem_store_checker_if;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    // Core side drives the store/address lines and consumes load data
    modport master (
        output memwrite,
        output dataadr,
        output writedata,
        input  readdata
    );

    // Memory side answers loads and absorbs stores
    modport slave (
        input  memwrite,
        input  dataadr,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/dmem_store_checker.sv
// rtl/dmem_store_checker.sv - data memory that also judges the store stream; optional watchdog via DMEM_STORE_CHECKER_WATCHDOG_EN
module dmem_store_checker #(
    parameter int unsigned DEPTH        = 64,
    parameter logic [31:0] PASS_ADDR    = 32'd84,
    parameter logic [31:0] PASS_DATA    = 32'd7,
    parameter logic [31:0] SCRATCH_ADDR = 32'd80,
    parameter int unsigned WDOG_CYCLES  = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_store_checker_if.slave  bus,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [15:0]          store_count,
    output logic [31:0]          last_store_adr
);

    localparam int unsigned AW = $clog2(DEPTH);

`ifdef DMEM_STORE_CHECKER_WATCHDOG_EN
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;
`endif

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] word_idx;
    state_t        state;
    logic          store_pass;
    logic          store_fail;

    // Word index drops the byte offset and aliases high bits modulo DEPTH
    assign word_idx     = bus.dataadr[AW+1:2];
    assign bus.readdata = mem[word_idx];

    // Memory array: written on every store, independent of reset and verdict
    always_ff @(posedge clk) begin
        if (bus.memwrite) begin
            mem[word_idx] <= bus.writedata;
        end
    end

    // Classify the current store; checker compares full 32-bit addresses, no aliasing
    always_comb begin
        store_pass = 1'b0;
        store_fail = 1'b0;
        if (bus.memwrite) begin
            store_pass = (bus.dataadr == PASS_ADDR) && (bus.writedata == PASS_DATA);
            store_fail = !store_pass && (bus.dataadr != SCRATCH_ADDR);
        end
    end

`ifdef DMEM_STORE_CHECKER_WATCHDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES) - 32'd1;

    logic [31:0] wdog_cnt;
    logic        wdog_expire;
    logic        timeout_r;

    // Expiry lands on the edge where the count reaches WDOG_CYCLES
    assign wdog_expire = (wdog_cnt >= WDOG_LAST);
    assign timeout     = timeout_r;

    // Watchdog counts non-reset edges only while the run is undecided
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt <= '0;
        end else if (state == ST_RUN) begin
            wdog_cnt <= wdog_cnt + 32'd1;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = |WDOG_CYCLES;
    assign timeout     = 1'b0;
`endif

    // Verdict FSM with registered outputs; deciding stores beat watchdog expiry
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
            done  <= 1'b0;
            pass  <= 1'b0;
`ifdef DMEM_STORE_CHECKER_WATCHDOG_EN
            timeout_r <= 1'b0;
`endif
        end else if (state == ST_RUN) begin
            if (store_pass) begin
                state <= ST_PASS;
                done  <= 1'b1;
                pass  <= 1'b1;
            end else if (store_fail) begin
                state <= ST_FAIL;
                done  <= 1'b1;
`ifdef DMEM_STORE_CHECKER_WATCHDOG_EN
            end else if (wdog_expire) begin
                state     <= ST_TIMEOUT;
                done      <= 1'b1;
                timeout_r <= 1'b1;
`endif
            end
        end
    end

    // Store statistics, counted in every state except on reset edges
    always_ff @(posedge clk) begin
        if (reset) begin
            store_count    <= '0;
            last_store_adr <= '0;
        end else if (bus.memwrite) begin
            if (store_count != 16'hFFFF) begin
                store_count <= store_count + 16'd1;
            end
            last_store_adr <= bus.dataadr;
        end
    end

endmodule

// File: tb/tb_dmem_store_checker.sv
// tb/tb_dmem_store_checker.sv - randomized self-checking bench for dmem_store_checker
module tb_dmem_store_checker;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned WDOG  = 20;
`ifdef DMEM_STORE_CHECKER_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam int V_RUN = 0, V_PASS = 1, V_FAIL = 2, V_TIMEOUT = 3;

    logic        clk;
    logic        reset;
    logic        done, pass, timeout;
    logic [15:0] store_count;
    logic [31:0] last_store_adr;

    dmem_store_checker_if bus();

    dmem_store_checker #(
        .DEPTH(DEPTH), .PASS_ADDR(32'd84), .PASS_DATA(32'd7),
        .SCRATCH_ADDR(32'd80), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .done(done), .pass(pass), .timeout(timeout),
        .store_count(store_count), .last_store_adr(last_store_adr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_passed = 0;

    // reference model state
    logic [31:0] mm [int];
    int          m_verdict;
    int          m_count;
    logic [31:0] m_last;
    int          m_cycles;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int widx(input logic [31:0] adr);
        return int'((adr / 4) % DEPTH);
    endfunction

    task automatic check_status(input string tag);
        check({tag, " verdict"}, {61'd0, done, pass, timeout},
              {61'd0, m_verdict != V_RUN, m_verdict == V_PASS, m_verdict == V_TIMEOUT});
        check({tag, " count"}, {48'd0, store_count}, 64'(m_count));
        check({tag, " last"}, {32'd0, last_store_adr}, {32'd0, m_last});
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        bus.memwrite = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_verdict = V_RUN;
        m_count   = 0;
        m_last    = '0;
        m_cycles  = 0;
    endtask

    // one clock: drive, check load data before the edge, model the edge, check status after
    task automatic cycle(input string tag, input bit we, input logic [31:0] adr, input logic [31:0] data);
        int i;
        bus.memwrite  = we;
        bus.dataadr   = adr;
        bus.writedata = data;
        #1;
        i = widx(adr);
        if (mm.exists(i)) check({tag, " rd"}, {32'd0, bus.readdata}, {32'd0, mm[i]});
        @(posedge clk);
        if (we) begin
            mm[i] = data;
            if (m_count < 65535) m_count++;
            m_last = adr;
        end
        if (m_verdict == V_RUN) begin
            m_cycles++;
            if (we && adr == 32'd84 && data == 32'd7)  m_verdict = V_PASS;
            else if (we && adr != 32'd80)             m_verdict = V_FAIL;
            else if (WD_EN && m_cycles >= int'(WDOG)) m_verdict = V_TIMEOUT;
        end
        @(negedge clk);
        bus.memwrite = 1'b0;
        check_status(tag);
    endtask

    task automatic read_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        bus.memwrite = 1'b0;
        bus.dataadr  = adr;
        #1;
        check(tag, {32'd0, bus.readdata}, {32'd0, exp});
    endtask

    initial begin
        logic [31:0] a, d;
        int r, len;
        reset = 1'b1;
        bus.memwrite  = 1'b0;
        bus.dataadr   = '0;
        bus.writedata = '0;

        // reset state
        do_reset(2);
        check("rst done", {63'd0, done}, 64'd0);
        check("rst pass", {63'd0, pass}, 64'd0);
        check("rst timeout", {63'd0, timeout}, 64'd0);
        check("rst count", {48'd0, store_count}, 64'd0);
        check("rst last", {32'd0, last_store_adr}, 64'd0);

        // scratch then pass mailbox
        cycle("pass1", 1'b1, 32'd80, 32'd5);
        cycle("pass2", 1'b1, 32'd84, 32'd7);
        check("pass done", {63'd0, done}, 64'd1);
        check("pass pass", {63'd0, pass}, 64'd1);
        check("pass count", {48'd0, store_count}, 64'd2);
        check("pass last", {32'd0, last_store_adr}, 64'd84);

        // wrong data at mailbox fails, later good store cannot rescue it
        do_reset(1);
        cycle("bad1", 1'b1, 32'd84, 32'd9);
        check("bad verdict", {62'd0, done, pass}, 64'b10);
        cycle("bad2", 1'b1, 32'd84, 32'd7);
        check("bad sticky", {62'd0, done, pass}, 64'b10);
        check("bad count", {48'd0, store_count}, 64'd2);

        // aliasing on reads; store to 4 fails the run
        do_reset(1);
        cycle("alias st", 1'b1, 32'd4, 32'hDEADBEEF);
        read_chk("alias rd0", 32'd4, 32'hDEADBEEF);
        read_chk("alias rd1", 32'd4 + 4 * DEPTH, 32'hDEADBEEF);
        read_chk("alias rd2", 32'd7, 32'hDEADBEEF);
        check("alias verdict", {62'd0, done, pass}, 64'b10);

        // store latency on scratch word
        do_reset(1);
        cycle("scr1", 1'b1, 32'd80, 32'd5);
        bus.memwrite = 1'b1; bus.dataadr = 32'd80; bus.writedata = 32'd3;
        #1;
        check("scr old", {32'd0, bus.readdata}, 64'd5);
        @(posedge clk);
        mm[widx(32'd80)] = 32'd3;
        m_count++; m_last = 32'd80; m_cycles++;
        @(negedge clk);
        bus.memwrite = 1'b0;
        check("scr new", {32'd0, bus.readdata}, 64'd3);
        check("scr done", {63'd0, done}, 64'd0);
        check_status("scr");

        // reset after pass clears everything, then a stray store fails
        cycle("rp1", 1'b1, 32'd84, 32'd7);
        check("rp pass", {63'd0, pass}, 64'd1);
        do_reset(1);
        check("rp done0", {63'd0, done}, 64'd0);
        check("rp pass0", {63'd0, pass}, 64'd0);
        check("rp count0", {48'd0, store_count}, 64'd0);
        check("rp last0", {32'd0, last_store_adr}, 64'd0);
        cycle("rp2", 1'b1, 32'd88, 32'd1);
        check("rp fail", {62'd0, done, pass}, 64'b10);

        if (WD_EN) begin
            do_reset(1);
            for (int k = 1; k < int'(WDOG); k++) cycle("wd idle", 1'b0, 32'd80, 32'd0);
            check("wd before", {63'd0, timeout}, 64'd0);
            cycle("wd edge", 1'b0, 32'd80, 32'd0);
            check("wd timeout", {62'd0, done, timeout}, 64'b11);
            do_reset(1);
            for (int k = 1; k < int'(WDOG); k++) cycle("wd idle2", 1'b0, 32'd80, 32'd0);
            cycle("wd race", 1'b1, 32'd84, 32'd7);
            check("wd race", {61'd0, done, pass, timeout}, 64'b110);
        end

        // randomized runs against the model
        for (int run = 0; run < 30; run++) begin
            do_reset(int'($urandom_range(1, 2)));
            len = int'($urandom_range(3, 40));
            for (int c = 0; c < len; c++) begin
                r = int'($urandom_range(0, 11));
                d = $urandom;
                if (r <= 5)      cycle("rnd scr", 1'b1, 32'd80, d);
                else if (r == 6) cycle("rnd mbx", 1'b1, 32'd84, ($urandom_range(0, 1) != 0) ? 32'd7 : d);
                else if (r == 7) begin
                    a = 32'($urandom_range(0, 255));
                    cycle("rnd lo", 1'b1, a, d);
                end else if (r == 8) cycle("rnd hi", 1'b1, $urandom, d);
                else begin
                    a = 32'($urandom_range(0, 4 * DEPTH * 3));
                    cycle("rnd rd", 1'b0, a, d);
                end
            end
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_store_checker.md
# dmem_store_checker

Data-memory responder for the single-cycle core's `dataadr`/`writedata`/`memwrite` port. It stores and returns data like normal data memory, and also judges the store stream in hardware, so a run reports pass/fail on pins instead of through a simulation monitor. It sits beside the core inside `top` and is the slave end of the core's data-memory interface.

## Interface
- `DEPTH`, 64: number of 32-bit words; power of two.
- `PASS_ADDR`, 84: byte address of the pass mailbox.
- `PASS_DATA`, 7: value that must be stored at `PASS_ADDR` to pass.
- `SCRATCH_ADDR`, 80: the only other byte address the program may store to.
- `WDOG_CYCLES`, 1000: watchdog limit in clock cycles; used only when the watchdog is compiled in.

Ports:
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: synchronous, active-high.
- `memwrite`, in, 1: store strobe from the core.
- `dataadr`, in, 32: byte address.
- `writedata`, in, 32: store data.
- `readdata`, out, 32: load data, combinational.
- `done`, out, 1: verdict reached. Reset value 0.
- `pass`, out, 1: verdict is pass. Reset value 0.
- `timeout`, out, 1: watchdog expired. Reset value 0.
- `store_count`, out, 16: stores accepted since reset. Reset value 0.
- `last_store_adr`, out, 32: address of the most recent store. Reset value 0.

## Operation
- Word index is `dataadr[log2(DEPTH)+1:2]`.
  - `dataadr[1:0]` is ignored.
  - Higher address bits alias modulo `DEPTH`.
- Read: `readdata` = mem[index], combinational from `dataadr`. No enable.
- Write: when `memwrite`=1 at a rising edge, mem[index] <= `writedata`.
  - This happens in every state, including after a verdict.
- Memory contents are not affected by `reset`.
- Verdict FSM states: RUN (reset state), PASS, FAIL, TIMEOUT.
- In RUN, on an edge with `memwrite`=1, the first matching rule applies:
  1. `dataadr`==`PASS_ADDR` and `writedata`==`PASS_DATA` → PASS.
  2. `dataadr`!=`SCRATCH_ADDR` → FAIL. This includes a store to `PASS_ADDR` with the wrong data.
  3. Otherwise → stay in RUN.
- Address comparisons use all 32 bits; aliasing does not apply to the checker.
- PASS, FAIL and TIMEOUT are terminal; only `reset` leaves them.
- Outputs by state:
  - `done` = (state != RUN).
  - `pass` = (state == PASS).
  - `timeout` = (state == TIMEOUT).
- `store_count` increments on every edge with `memwrite`=1, in any state, and saturates at 0xFFFF.
- `last_store_adr` loads `dataadr` on every store.

## Timing
- Load latency: 0 cycles, combinational.
- Store latency: 1 edge. A read of the same word during the store cycle returns the old data; the new data is visible after the edge.
- Status outputs are registered. The verdict for a store sampled at edge N is visible after edge N and is stable for the following negedge.
- `reset` sampled high at an edge:
  - FSM → RUN.
  - All status outputs → 0.
  - Watchdog counter → 0.
  - A `memwrite` on that same edge still writes memory but is not counted or checked.
- Reset during a run discards the verdict; checking restarts with the first store after `reset` deasserts.

## Configuration
- `DMEM_STORE_CHECKER_WATCHDOG_EN` defined:
  - A 32-bit cycle counter increments on each non-reset edge while in RUN.
  - When the counter reaches `WDOG_CYCLES`, and that edge has no qualifying store, the FSM → TIMEOUT, giving `done`=1, `pass`=0, `timeout`=1.
  - A PASS or FAIL store on the expiry edge takes priority over TIMEOUT.
- Not defined:
  - No counter and no TIMEOUT state.
  - `timeout` is tied to 0.
  - A run that never issues a deciding store stays in RUN indefinitely.

## Test plan
- Reset 2 cycles, then store 5 to 80, then 7 to 84 → after the second store: `done`=1, `pass`=1, `store_count`=2, `last_store_adr`=84.
- Store 9 to 84 → `done`=1, `pass`=0 after that edge. A later store of 7 to 84 does not change the verdict, but `store_count` increments.
- Store 0xDEADBEEF to 4, then drive `dataadr`=4 and `dataadr`=4+4·`DEPTH` → `readdata`=0xDEADBEEF for both. The verdict is FAIL because 4 is not `SCRATCH_ADDR`.
- Store 3 to 80; in the same cycle, `readdata` at 80 shows the old value, and after the edge shows 3. `done` stays 0.
- Reach PASS, then assert `reset` for 1 cycle → all status outputs 0. Then store 1 to 88 → FAIL.
- With watchdog compiled in and `WDOG_CYCLES`=20, issue no stores → `timeout`=1 and `done`=1 after edge 20. A rerun that stores 7 to 84 exactly on edge 20 → `pass`=1 and `timeout`=0.
